// File: rtl/drm_rd_streamer.sv
// Streams a burst of consecutive words out of a simple-dual-port RAM read port
// onto a valid/ready interface, using a 2-entry skid FIFO to absorb RAM latency.
module drm_rd_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0]   MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  pend_q;
  logic                  pend_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;
  logic [1:0]            count_d;
  logic [ADDR_WIDTH:0]   len_sat;

  assign m_valid     = (count_q != 2'd0);
  assign m_data      = fifo_data_q[rd_ptr_q];
  assign m_last      = m_valid & fifo_last_q[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_rd_addr = addr_q;

  // Credit counts words already buffered plus the one in flight from the RAM,
  // minus the word leaving this cycle, so the FIFO can never be overrun.
  always_comb begin
    pop     = m_valid & m_ready;
    occ     = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    issue   = (state_q == RUN) && (occ < 3'd2);
    count_d = count_q + {1'b0, pend_q} - {1'b0, pop};
    len_sat = (length > MAX_LEN) ? MAX_LEN : length;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remain_q       <= '0;
      pend_q         <= 1'b0;
      pend_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        pend_q      <= 1'b0;
        pend_last_q <= 1'b0;
        count_q     <= 2'd0;
        wr_ptr_q    <= 1'b0;
        rd_ptr_q    <= 1'b0;
      end else begin
        if (pend_q) begin
          fifo_data_q[wr_ptr_q] <= ram_rd_data;
          fifo_last_q[wr_ptr_q] <= pend_last_q;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q     <= count_d;
        pend_q      <= issue;
        pend_last_q <= issue && (remain_q == REM_ONE);
        if (issue) begin
          addr_q   <= addr_q + ADDR_ONE;
          remain_q <= remain_q - REM_ONE;
        end

        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              if (len_sat == LEN_ZERO) begin
                done_q <= 1'b1;
              end else begin
                state_q  <= RUN;
                busy_q   <= 1'b1;
                addr_q   <= base_addr;
                remain_q <= len_sat;
              end
            end
          end
          RUN: begin
            if (issue && (remain_q == REM_ONE)) state_q <= DRAIN;
          end
          DRAIN: begin
            if (pop && m_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drm_rd_streamer.sv
// Randomized bench for drm_rd_streamer: a behavioural RAM plus a queue-based
// model of the expected word stream for each burst.
module tb_drm_rd_streamer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int n_hs; int n_bad; int n_unstable; int n_busy_bad;
    int t_first; int t_done; int t_last; int busy_at_done; int max_gap;
  } res_t;

  drm_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) ram_rd_data <= ram[ram_rd_addr];

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic fill_linear;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
  endtask

  task automatic fill_random;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
  endtask

  // Issues one burst and watches the stream until done or the cycle budget runs out.
  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] len,
                           input bit rnd_ready, input bit poke, output res_t r);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] pd;
    logic          pl;
    bit            stall;
    int            nexp, t, prev_hs;
    nexp = (int'(len) > DEPTH) ? DEPTH : int'(len);
    for (int i = 0; i < nexp; i++) expq.push_back(ram[(int'(b) + i) % DEPTH]);
    r = '{default: 0};
    r.t_first = -1; r.t_done = -1; r.t_last = -1;
    stall = 0; prev_hs = -1; pd = '0; pl = 1'b0;
    base_addr = b; length = len; start = 1'b1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick;
    start = 1'b0;
    t = 0;
    while (t < nexp * 8 + 20) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      start = poke && (t == 1);
      if (poke && t == 1) begin base_addr = ~b; length = len + 3; end
      if (done === 1'b1) begin r.t_done = t; r.busy_at_done = int'(busy); break; end
      if (busy !== 1'b1) r.n_busy_bad++;
      if (stall && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) r.n_unstable++;
      if (m_valid === 1'b1) begin
        if (r.t_first < 0) r.t_first = t;
        if (m_ready) begin
          if (r.n_hs >= nexp || m_data !== expq[r.n_hs] || m_last !== (r.n_hs == nexp - 1))
            r.n_bad++;
          if (prev_hs >= 0 && t - prev_hs - 1 > r.max_gap) r.max_gap = t - prev_hs - 1;
          prev_hs = t;
          r.n_hs++;
          r.t_last = t;
        end
      end
      stall = (m_valid === 1'b1) && !m_ready;
      pd = m_data; pl = m_last;
      tick;
      t++;
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", m_valid); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b want 0", m_last); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL rst_data got %h want 0", m_data); end
    n_vec++; if (ram_rd_addr !== '0) begin n_err++; $display("FAIL rst_addr got %h want 0", ram_rd_addr); end
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    res_t r;
    fill_linear;
    run_burst(10'h010, 11'd4, 1'b0, 1'b0, r);
    n_vec++; if (r.n_hs !== 4) begin n_err++; $display("FAIL basic_count got %0d want 4", r.n_hs); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL basic_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_first !== 2) begin n_err++; $display("FAIL basic_first got %0d want 2", r.t_first); end
    n_vec++; if (r.max_gap !== 0) begin n_err++; $display("FAIL basic_gap got %0d want 0", r.max_gap); end
    n_vec++; if (r.t_done !== 6) begin n_err++; $display("FAIL basic_done got %0d want 6", r.t_done); end
    n_vec++; if (r.busy_at_done !== 0) begin n_err++; $display("FAIL basic_busy_done got %0d want 0", r.busy_at_done); end
    n_vec++; if (r.n_busy_bad !== 0) begin n_err++; $display("FAIL basic_busy got %0d low want 0", r.n_busy_bad); end
  endtask

  task automatic test_wrap;
    res_t r;
    run_burst(10'h3FE, 11'd4, 1'b0, 1'b0, r);
    n_vec++; if (r.n_hs !== 4) begin n_err++; $display("FAIL wrap_count got %0d want 4", r.n_hs); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL wrap_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_done !== 6) begin n_err++; $display("FAIL wrap_done got %0d want 6", r.t_done); end
  endtask

  task automatic test_zero_len;
    res_t r;
    run_burst(AW'($urandom), 11'd0, 1'b0, 1'b0, r);
    n_vec++; if (r.t_done !== 0) begin n_err++; $display("FAIL zero_done got %0d want 0", r.t_done); end
    n_vec++; if (r.t_first !== -1) begin n_err++; $display("FAIL zero_valid got %0d want -1", r.t_first); end
    n_vec++; if (r.busy_at_done !== 0) begin n_err++; $display("FAIL zero_busy got %0d want 0", r.busy_at_done); end
    tick;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse got %b want 0", done); end
  endtask

  task automatic test_saturate;
    res_t r;
    run_burst(AW'($urandom), 11'd2047, 1'b0, 1'b0, r);
    n_vec++; if (r.n_hs !== DEPTH) begin n_err++; $display("FAIL sat_count got %0d want %0d", r.n_hs, DEPTH); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL sat_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_done !== DEPTH + 2) begin n_err++; $display("FAIL sat_done got %0d want %0d", r.t_done, DEPTH + 2); end
    n_vec++; if (r.max_gap !== 0) begin n_err++; $display("FAIL sat_gap got %0d want 0", r.max_gap); end
  endtask

  task automatic test_random_ready;
    res_t r;
    int len;
    fill_random;
    for (int it = 0; it < 8; it++) begin
      len = (it == 0) ? 8 : int'($urandom_range(1, 40));
      run_burst(AW'($urandom), (AW+1)'(len), 1'b1, 1'b0, r);
      n_vec++; if (r.n_hs !== len) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", it, r.n_hs, len); end
      n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL rnd_data[%0d] got %0d bad want 0", it, r.n_bad); end
      n_vec++; if (r.n_unstable !== 0) begin n_err++; $display("FAIL rnd_stable[%0d] got %0d want 0", it, r.n_unstable); end
      n_vec++; if (r.n_busy_bad !== 0) begin n_err++; $display("FAIL rnd_busy[%0d] got %0d want 0", it, r.n_busy_bad); end
      n_vec++; if (r.t_done !== r.t_last + 1) begin n_err++; $display("FAIL rnd_done[%0d] got %0d want %0d", it, r.t_done, r.t_last + 1); end
    end
  endtask

  task automatic test_start_ignored;
    res_t r;
    run_burst(AW'($urandom), 11'd5, 1'b0, 1'b1, r);
    n_vec++; if (r.n_hs !== 5) begin n_err++; $display("FAIL busy_start_count got %0d want 5", r.n_hs); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL busy_start_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_done !== 7) begin n_err++; $display("FAIL busy_start_done got %0d want 7", r.t_done); end
  endtask

  task automatic test_abort;
    res_t r;
    int hs, t;
    bit seen_done, seen_valid;
    base_addr = AW'($urandom); length = 11'd16; start = 1'b1; m_ready = 1'b1;
    tick;
    start = 1'b0; hs = 0; t = 0;
    while (hs < 3 && t < 20) begin
      if (m_valid === 1'b1) hs++;
      tick;
      t++;
    end
    n_vec++; if (hs !== 3) begin n_err++; $display("FAIL abort_pre_hs got %0d want 3", hs); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", m_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    seen_done = 0; seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) seen_done = 1;
      if (m_valid === 1'b1) seen_valid = 1;
      tick;
    end
    n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b want 0", seen_done); end
    n_vec++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_valid got %b want 0", seen_valid); end
    run_burst(AW'($urandom), 11'd2, 1'b0, 1'b0, r);
    n_vec++; if (r.n_hs !== 2) begin n_err++; $display("FAIL abort_next_count got %0d want 2", r.n_hs); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL abort_next_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_done !== 4) begin n_err++; $display("FAIL abort_next_done got %0d want 4", r.t_done); end
  endtask

  task automatic test_idle_abort;
    bit seen;
    base_addr = AW'($urandom); length = 11'd3; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_abort_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL start_abort_done got %b want 0", done); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid === 1'b1 || busy === 1'b1 || done === 1'b1) seen = 1;
      tick;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL start_abort_activity got %b want 0", seen); end
  endtask

  task automatic test_reset_midburst;
    res_t r;
    bit seen;
    base_addr = AW'($urandom); length = 11'd10; start = 1'b1; m_ready = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    #2;
    rd_rst_n = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", m_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", m_data); end
    n_vec++; if (ram_rd_addr !== '0) begin n_err++; $display("FAIL mid_rst_addr got %h want 0", ram_rd_addr); end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL mid_rst_last got %b want 0", m_last); end
    tick;
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    tick;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || m_valid === 1'b1) seen = 1;
      tick;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_residue got %b want 0", seen); end
    run_burst(AW'($urandom), 11'd1, 1'b0, 1'b0, r);
    n_vec++; if (r.n_hs !== 1) begin n_err++; $display("FAIL mid_rst_next_count got %0d want 1", r.n_hs); end
    n_vec++; if (r.n_bad !== 0) begin n_err++; $display("FAIL mid_rst_next_data got %0d bad want 0", r.n_bad); end
    n_vec++; if (r.t_first !== 2) begin n_err++; $display("FAIL mid_rst_next_first got %0d want 2", r.t_first); end
    n_vec++; if (r.t_done !== 3) begin n_err++; $display("FAIL mid_rst_next_done got %0d want 3", r.t_done); end
  endtask

  initial begin
    fill_linear;
    test_reset;
    test_basic;
    test_wrap;
    test_zero_len;
    test_saturate;
    test_random_ready;
    test_start_ignored;
    test_abort;
    test_idle_abort;
    test_reset_midburst;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
